// File: rtl/mv_row_sequencer.sv
// Row-at-a-time sequencer for a matrix-vector product on one MAC node.
// It issues operand addresses, holds the node controls, drains the pipeline and hands off each row result.
module mv_row_sequencer #(
    parameter int LW      = 10,
    parameter int RW      = 8,
    parameter int MAC_LAT = 3,
    parameter int AW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [LW-1:0] cfg_len,
    input  logic [RW-1:0] cfg_rows,
    input  logic          cfg_sub,
    input  logic          cfg_cascade,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [LW-1:0] vec_addr,
    output logic [AW-1:0] mat_addr,
    output logic          op_zero,
    output logic          node_ce,
    output logic          node_sclr,
    output logic          node_subtract,
    output logic          node_csel,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_row
);

    // Drain covers one BRAM read cycle, the node input buffer and the MAC core.
    localparam int D   = MAC_LAT + 2;
    localparam int DCW = $clog2(D + 1);

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, RES} state_t;

    state_t         state, state_d;
    logic [LW-1:0]  len_q;
    logic [RW-1:0]  rows_q;
    logic [DCW-1:0] dcnt, dcnt_d;
    logic [LW-1:0]  vec_d;
    logic [AW-1:0]  mat_d;
    logic [RW-1:0]  row_d;
    logic           accept, reject, handshake, last_row;

    always_comb begin
        accept    = (state == IDLE) && start && !abort && (cfg_len != '0) && (cfg_rows != '0);
        reject    = (state == IDLE) && start && !abort && ((cfg_len == '0) || (cfg_rows == '0));
        handshake = (state == RES) && res_ready;
        last_row  = (res_row == rows_q - RW'(1));

        state_d = state;
        dcnt_d  = dcnt;
        vec_d   = vec_addr;
        mat_d   = mat_addr;
        row_d   = res_row;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = CLR;
                    row_d   = '0;
                    mat_d   = '0;
                end
            end
            CLR: state_d = FEED;
            FEED: begin
                // mat_addr runs across rows, so row r starts at r*N without a multiply.
                mat_d = mat_addr + AW'(1);
                if (vec_addr == len_q - LW'(1)) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    vec_d = vec_addr + LW'(1);
                end
            end
            DRAIN: begin
                if (dcnt == DCW'(D - 1)) state_d = RES;
                else                     dcnt_d  = dcnt + DCW'(1);
            end
            RES: begin
                if (res_ready) begin
                    if (last_row) begin
                        state_d = IDLE;
                    end else begin
                        state_d = CLR;
                        row_d   = res_row + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) state_d = IDLE;
        if (state_d == CLR) vec_d = '0;
    end

    // Every output is registered from the next-state decode, so it lines up with the state it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dcnt          <= '0;
            vec_addr      <= '0;
            mat_addr      <= '0;
            res_row       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rd_en         <= 1'b0;
            op_zero       <= 1'b0;
            node_ce       <= 1'b0;
            node_sclr     <= 1'b0;
            node_subtract <= 1'b0;
            node_csel     <= 1'b0;
            res_valid     <= 1'b0;
        end else begin
            state     <= state_d;
            dcnt      <= dcnt_d;
            vec_addr  <= vec_d;
            mat_addr  <= mat_d;
            res_row   <= row_d;
            busy      <= (state_d != IDLE);
            done      <= handshake && last_row && !abort;
            err       <= reject;
            rd_en     <= (state_d == FEED);
            op_zero   <= (state_d == DRAIN);
            node_ce   <= abort || (state_d == CLR) || (state_d == FEED) || (state_d == DRAIN);
            node_sclr <= abort || (state_d == CLR);
            res_valid <= (state_d == RES);
            if (accept) begin
                node_subtract <= cfg_sub;
                node_csel     <= cfg_cascade;
            end
        end
    end

    // Run geometry is only read while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            len_q  <= cfg_len;
            rows_q <= cfg_rows;
        end
    end

endmodule

// File: tb/tb_mv_row_sequencer.sv
// Directed bench for mv_row_sequencer: timeline, backpressure, degenerate config, abort, reset and address wrap.
module tb_mv_row_sequencer;

    localparam int LW = 10, RW = 8, MAC_LAT = 3, AW = 4;
    localparam int D = MAC_LAT + 2;

    logic          clk = 1'b0;
    logic          rst, start, abort, cfg_sub, cfg_cascade, res_ready;
    logic [LW-1:0] cfg_len;
    logic [RW-1:0] cfg_rows;
    logic          busy, done, err, rd_en, op_zero, node_ce, node_sclr;
    logic          node_subtract, node_csel, res_valid;
    logic [LW-1:0] vec_addr;
    logic [AW-1:0] mat_addr;
    logic [RW-1:0] res_row;

    int checks = 0;
    int failures = 0;
    int acc = 0;

    mv_row_sequencer #(.LW(LW), .RW(RW), .MAC_LAT(MAC_LAT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_len(cfg_len), .cfg_rows(cfg_rows), .cfg_sub(cfg_sub), .cfg_cascade(cfg_cascade),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en),
        .vec_addr(vec_addr), .mat_addr(mat_addr), .op_zero(op_zero),
        .node_ce(node_ce), .node_sclr(node_sclr), .node_subtract(node_subtract),
        .node_csel(node_csel), .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);       chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);         chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_vec"}, vec_addr, 0);    chk({tag, "_mat"}, mat_addr, 0);
        chk({tag, "_opz"}, op_zero, 0);     chk({tag, "_ce"}, node_ce, 0);
        chk({tag, "_sclr"}, node_sclr, 0);  chk({tag, "_sub"}, node_subtract, 0);
        chk({tag, "_csel"}, node_csel, 0);  chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_row"}, res_row, 0);
    endtask

    // Launch at t0 and check every cycle against the hand-derived row timeline:
    // phase 0 CLR, 1..n FEED, n+1..n+D DRAIN, then RES (row 0 held stall0 extra cycles).
    task automatic run(input int n, input int m, input int stall0, input logic sub, input bit poke);
        int per, l0, done_c, r, p;
        per    = n + D + 2;
        l0     = per + stall0;
        done_c = 1 + l0 + (m - 1) * per;
        cfg_len = LW'(n); cfg_rows = RW'(m); cfg_sub = sub; cfg_cascade = sub;
        res_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= done_c; c++) begin
            if (node_sclr) acc = 0;
            else if (rd_en) acc = acc + 1 * 2;
            if (c == done_c) begin
                chk("end_done", done, 1);      chk("end_busy", busy, 0);
                chk("end_valid", res_valid, 0); chk("end_ce", node_ce, 0);
            end else begin
                if (c - 1 < l0) begin r = 0; p = c - 1; end
                else begin r = 1 + (c - 1 - l0) / per; p = (c - 1 - l0) % per; end
                chk("busy", busy, 1);     chk("done", done, 0);   chk("err", err, 0);
                chk("sclr", node_sclr, int'(p == 0));
                chk("rd_en", rd_en, int'(p >= 1 && p <= n));
                chk("op_zero", op_zero, int'(p > n && p <= n + D));
                chk("ce", node_ce, int'(p <= n + D));
                chk("res_valid", res_valid, int'(p > n + D));
                chk("subtract", node_subtract, int'(sub));
                chk("csel", node_csel, int'(sub));
                if (p >= 1 && p <= n) begin
                    chk("vec_addr", vec_addr, p - 1);
                    chk("mat_addr", mat_addr, (r * n + p - 1) % 16);
                end
                if (p > n + D) begin
                    chk("res_row", res_row, r);
                    chk("acc", acc, 2 * n);
                    res_ready = !(r == 0 && (p - (n + D + 1)) < stall0);
                end else begin
                    res_ready = 1'b1;
                end
            end
            if (poke && c == 3) begin start = 1'b1; cfg_len = LW'(2); cfg_rows = RW'(1); end
            else start = 1'b0;
            if (c != done_c) step();
        end
        res_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_sub = 1'b0; cfg_cascade = 1'b0;
        res_ready = 1'b1; cfg_len = '0; cfg_rows = '0;
        step(); step();
        all_zero("reset");
        rst = 1'b0;
        step();

        run(4, 2, 0, 1'b0, 1'b0);       // basic two-row timeline
        step();
        run(4, 2, 5, 1'b0, 1'b0);       // row 0 result held under backpressure
        step();
        run(1, 1, 0, 1'b1, 1'b0);       // single element, subtract/cascade modes
        step();
        run(5, 4, 0, 1'b0, 1'b1);       // mat_addr wrap in row 3, start poked while busy
        step();

        cfg_len = '0; cfg_rows = RW'(3); start = 1'b1;
        step();
        start = 1'b0;
        chk("len0_err", err, 1); chk("len0_busy", busy, 0);
        step();
        chk("len0_err_clr", err, 0); chk("len0_busy2", busy, 0);
        cfg_len = LW'(3); cfg_rows = '0; start = 1'b1;
        step();
        start = 1'b0;
        chk("rows0_err", err, 1); chk("rows0_busy", busy, 0);
        step();
        chk("rows0_err_clr", err, 0);

        cfg_len = LW'(4); cfg_rows = RW'(2); start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("abort_in_drain", op_zero, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);   chk("abort_sclr", node_sclr, 1);
        chk("abort_ce", node_ce, 1);  chk("abort_valid", res_valid, 0);
        chk("abort_done", done, 0);   chk("abort_opz", op_zero, 0);
        chk("abort_err", err, 0);
        step();
        chk("abort2_sclr", node_sclr, 0); chk("abort2_ce", node_ce, 0);
        for (int i = 0; i < 12; i++) begin
            chk("post_abort_valid", res_valid, 0);
            chk("post_abort_done", done, 0);
            step();
        end

        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("collide_busy", busy, 0); chk("collide_sclr", node_sclr, 1);
        chk("collide_err", err, 0);
        step();
        chk("collide_busy2", busy, 0);

        cfg_len = LW'(8); cfg_rows = RW'(1); cfg_sub = 1'b1; cfg_cascade = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("pre_rst_rd_en", rd_en, 1);
        #2 rst = 1'b1;
        #1 all_zero("async_rst");
        step();
        all_zero("held_rst");
        rst = 1'b0;
        step();
        run(8, 1, 0, 1'b0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mv_row_sequencer.md
# mv_row_sequencer

Control FSM that drives one fixed-point MAC `node` through a matrix-vector product, one output row at a time. It issues operand-memory read addresses and holds the node's ce/sclr/subtract/csel controls, then waits out the operand and MAC pipeline. It presents each row result through a valid/ready handshake and pulses done after the last row. It sits between the AXI-lite register bank (start/config) and the node/operand BRAM datapath.

## Interface
- LW, 10: width of length/address counters (max vector length 2^LW-1)
- RW, 8: width of row counter
- MAC_LAT, 3: MAC core latency, A/B in to P out, cycles
- AW, 16: matrix address width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle launch request; sampled only in IDLE
- abort  in  1  synchronous abort; return to IDLE from any state
- cfg_len  in  LW  vector length N; latched on accepted start
- cfg_rows  in  RW  row count M; latched on accepted start
- cfg_sub  in  1  subtract mode; latched, drives node_subtract
- cfg_cascade  in  1  cascade enable; latched, drives node_csel
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final row handshake
- err  out  1  one-cycle pulse when start is rejected for N==0 or M==0
- rd_en  out  1  operand BRAM read enable, 1-cycle read latency
- vec_addr  out  LW  vector element index k
- mat_addr  out  AW  matrix element index row*N+k (running counter)
- op_zero  out  1  datapath forces ain/bin to 0 while high
- node_ce  out  1  MAC clock enable
- node_sclr  out  1  MAC synchronous clear
- node_subtract  out  1  registered cfg_sub
- node_csel  out  1  registered cfg_cascade
- res_valid  out  1  node res is final for res_row
- res_ready  in  1  downstream accepts result
- res_row  out  RW  row index of presented result

## Operation
- States: IDLE, CLR, FEED, DRAIN, RES.
- IDLE: start with N≥1 and M≥1 -> latch config, row=0, mat_addr=0, go to CLR. If N==0 or M==0, pulse err and stay in IDLE.
- CLR (1 cycle): node_sclr=1, node_ce=1, vec_addr=0; go to FEED.
- FEED (N cycles): rd_en=1, node_ce=1.
  - vec_addr counts 0..N-1; mat_addr increments every cycle and is never reset between rows.
  - After the k=N-1 cycle, go to DRAIN.
- DRAIN (D = 2+MAC_LAT cycles): node_ce=1, op_zero=1, rd_en=0.
  - D covers 1 BRAM cycle, 1 node input buffer and MAC_LAT.
  - Zeroed operands add nothing to the sum.
  - Go to RES.
- RES: node_ce=0 so P holds; res_valid=1, res_row=row.
  - On res_ready: if row==M-1, pulse done and go to IDLE; else row++ and go to CLR.
  - Without res_ready, stay in RES indefinitely with all outputs stable.
- Counters:
  - DRAIN counter is ceil(log2(D+1)) bits.
  - mat_addr wraps modulo 2^AW with no error flag; the caller sizes AW ≥ log2(N*M).
- abort (any state, highest priority): next cycle is IDLE with node_sclr=1, node_ce=1 for that one cycle. No done. err is not raised.
- start while busy: ignored, no effect on latched config.
- abort and start in the same IDLE cycle: abort wins; start is dropped.
- Config inputs may change while busy without effect.

## Timing
- Reset values: all outputs 0, state IDLE. node_subtract and node_csel reset to 0.
- Reset asserted mid-run: immediate return to IDLE with outputs 0. The MAC is not cleared by reset; the next CLR clears it.
- Cycle of accepted start = t0. CLR at t0+1. FEED at t0+2..t0+N+1. DRAIN at t0+N+2..t0+N+1+D. First res_valid at t0+N+2+D.
- Row period with res_ready tied high: N+D+2 cycles.
- res_valid, res_row and done are registered outputs.
- done is asserted in the cycle after the final handshake, and res_valid drops that same cycle.
- node_subtract and node_csel are stable from CLR through RES of every row.

## Test plan
- Reset: assert rst mid-FEED (N=8) -> next edge all outputs 0 and busy=0. The next start runs a full row correctly (bench uses the real node, vector all 1s, matrix all 2s, result 16 in the res scale).
- Basic, with MAC_LAT=3, N=4, M=2, ready tied high, start at t0 = cycle 0:
  - sclr at cycle 1; rd_en cycles 2-5 with vec 0..3 and mat 0..3; op_zero cycles 6-10; res_valid at 11 with row 0.
  - Second row: CLR at 12, mat 4..7 at cycles 13-16, res_valid at 22 with row 1; done at 23.
- Backpressure: same run with res_ready held low 5 cycles after res_valid -> node_ce=0, res_valid and res_row stable for 5 cycles, accepted on the 6th. Total run is 5 cycles longer.
- Degenerate config:
  - cfg_len=0 start -> err pulse 1 cycle, busy stays 0.
  - N=1, M=1 -> single rd_en cycle, res_valid at t0+2+1+5=t0+8, then done.
- Abort/start collisions:
  - abort during DRAIN -> next cycle IDLE with sclr=1 and ce=1, no res_valid, no done.
  - start pulsed while busy -> latched cfg_len is unchanged and the run completes with its original N.
- Mode and wrap:
  - cfg_sub=1, cfg_cascade=1 -> node_subtract and node_csel are 1 from CLR through RES.
  - AW=4, N=5, M=4 -> mat_addr wraps 15 -> 0 during row 3.
